// File: rtl/clock_pkg.sv
// Shared clock definitions: field limits, mode encoding, blank-bit positions and
// small helpers used by the time controller and the multiplexed displayer.
package clock_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    localparam int unsigned BLANK_SEC  = 0;
    localparam int unsigned BLANK_MIN  = 1;
    localparam int unsigned BLANK_HOUR = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
        return (value >= max) ? '0 : value + 6'd1;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            RUN:      n = SET_HOUR;
            SET_HOUR: n = SET_MIN;
            SET_MIN:  n = SET_SEC;
            default:  n = RUN;
        endcase
        return n;
    endfunction

    // Only the field being edited can go dark, and only in its dark half-period.
    function automatic logic [2:0] blank_mask(input mode_e m, input logic dark);
        logic [2:0] mask;
        mask = '0;
        if (dark) begin
            case (m)
                SET_HOUR: mask[BLANK_HOUR] = 1'b1;
                SET_MIN:  mask[BLANK_MIN]  = 1'b1;
                SET_SEC:  mask[BLANK_SEC]  = 1'b1;
                default:  mask = '0;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/clock_time_controller_if.sv
// Button inputs and time/blank/mode outputs between the time controller and its
// surroundings (buttons in, displayer out).
interface clock_time_controller_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hour;
    logic [2:0] blank;
    logic [1:0] mode;

    modport master (
        output btn_mode, btn_inc,
        input  sec, min, hour, blank, mode
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec, min, hour, blank, mode
    );
endinterface

// File: rtl/button_debounce.sv
// Raw button conditioning: 2-flop synchronizer, stability counter, and a one-cycle
// pulse on each accepted 0->1 change of the debounced level.
module button_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic clk_1000hz,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with the accepted level.
    always_ff @(posedge clk_1000hz or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (sync[1] != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync[1];
                    cnt    <= '0;
                    pulse  <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_time_controller.sv
// HH:MM:SS sequencing controller: once-per-second time advance in RUN, and a
// two-button set mode that edits one field at a time and blinks it.
module clock_time_controller
    import clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC  = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned BLINK_HALF     = 250
) (
    input  logic                   clk_1000hz,
    input  logic                   rst_n,
    clock_time_controller_if.slave bus
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned BW = (BLINK_HALF > 0) ? $clog2(2 * BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_MID  = BW'(BLINK_HALF);

    logic mode_pulse;
    logic inc_pulse;

    mode_e         state;
    mode_e         state_nxt;
    logic [PW-1:0] prescaler;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_nxt;
    logic [5:0]    sec_q;
    logic [5:0]    min_q;
    logic [5:0]    hour_q;
    logic [2:0]    blank_q;
    logic          inc_ok;
    logic          tick;

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mode (
        .clk_1000hz (clk_1000hz),
        .rst_n      (rst_n),
        .btn        (bus.btn_mode),
        .pulse      (mode_pulse)
    );

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_inc (
        .clk_1000hz (clk_1000hz),
        .rst_n      (rst_n),
        .btn        (bus.btn_inc),
        .pulse      (inc_pulse)
    );

    // A mode press in the same cycle as an inc press swallows the inc.
    always_comb begin
        state_nxt = state;
        blink_nxt = blink_cnt;
        inc_ok    = inc_pulse && !mode_pulse && (state != RUN);
        tick      = (state == RUN) && (prescaler == PRE_LAST);
        if (mode_pulse) begin
            state_nxt = next_mode(state);
        end
        if (state_nxt == RUN || mode_pulse || inc_ok) begin
            blink_nxt = '0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
        end else begin
            blink_nxt = blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_1000hz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            prescaler <= '0;
            blink_cnt <= '0;
            blank_q   <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_nxt;
            blank_q   <= blank_mask(state_nxt, blink_nxt >= BLINK_MID);

            // Prescaler only runs while staying in RUN, so re-entry starts a full second.
            if (state == RUN && state_nxt == RUN) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
            end else begin
                prescaler <= '0;
            end

            if (tick) begin
                if (sec_q == SEC_MAX) begin
                    sec_q <= '0;
                    if (min_q == MIN_MAX) begin
                        min_q  <= '0;
                        hour_q <= wrap_inc(hour_q, HOUR_MAX);
                    end else begin
                        min_q <= min_q + 6'd1;
                    end
                end else begin
                    sec_q <= sec_q + 6'd1;
                end
            end else if (inc_ok) begin
                case (state)
                    SET_HOUR: hour_q <= wrap_inc(hour_q, HOUR_MAX);
                    SET_MIN:  min_q  <= wrap_inc(min_q, MIN_MAX);
                    SET_SEC:  sec_q  <= wrap_inc(sec_q, SEC_MAX);
                    default:  ;
                endcase
            end
        end
    end

    assign bus.sec   = sec_q;
    assign bus.min   = min_q;
    assign bus.hour  = hour_q;
    assign bus.blank = blank_q;
    assign bus.mode  = state;

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed-plus-random bench for clock_time_controller, checked every cycle against
// a seconds-since-midnight reference model.
module tb_clock_time_controller;

    localparam int T   = 10;
    localparam int D   = 3;
    localparam int H   = 4;
    localparam int LAT = 2 + D + 1;

    logic clk_1000hz = 1'b0;
    logic rst_n;

    clock_time_controller_if bus ();

    clock_time_controller #(
        .TICKS_PER_SEC  (T),
        .DEBOUNCE_TICKS (D),
        .BLINK_HALF     (H)
    ) dut (
        .clk_1000hz (clk_1000hz),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 clk_1000hz = ~clk_1000hz;

    int cyc, mode_at, inc_at;
    int m_mode, m_h, m_m, m_s;
    int base, since, blink_since;
    int checks, errors;

    function automatic int run_total();
        return (base + (cyc - since) / T) % 86400;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0; base = 0; since = 0; blink_since = 0;
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
        mode_at = -1; inc_at = -1;
    endtask

    task automatic model_edge();
        int t;
        if (cyc == mode_at) begin
            if (m_mode == 0) begin
                t = run_total();
                m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
            end
            if (m_mode == 3) begin
                base = m_h * 3600 + m_m * 60 + m_s;
                since = cyc;
            end
            m_mode = (m_mode + 1) % 4;
            blink_since = cyc;
        end else if (cyc == inc_at && m_mode != 0) begin
            case (m_mode)
                1: m_h = (m_h + 1) % 24;
                2: m_m = (m_m + 1) % 60;
                default: m_s = (m_s + 1) % 60;
            endcase
            blink_since = cyc;
        end
    endtask

    task automatic check_outputs();
        int t, eh, em, es, eb;
        if (m_mode == 0) begin
            t = run_total();
            eh = t / 3600; em = (t / 60) % 60; es = t % 60; eb = 0;
        end else begin
            eh = m_h; em = m_m; es = m_s;
            eb = 0;
            if (((cyc - blink_since) % (2 * H)) >= H)
                eb = (m_mode == 1) ? 4 : (m_mode == 2) ? 2 : 1;
        end
        check("sec", bus.sec, es);
        check("min", bus.min, em);
        check("hour", bus.hour, eh);
        check("blank", bus.blank, eb);
        check("mode", bus.mode, m_mode);
    endtask

    task automatic cycle();
        @(posedge clk_1000hz);
        cyc++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic press(input logic m, input logic i);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        if (m) mode_at = cyc + LAT;
        if (i) inc_at  = cyc + LAT;
        repeat (8) cycle();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sec"}, bus.sec, 0);
        check({tag, "_min"}, bus.min, 0);
        check({tag, "_hour"}, bus.hour, 0);
        check({tag, "_blank"}, bus.blank, 0);
        check({tag, "_mode"}, bus.mode, 0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        model_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        @(posedge clk_1000hz); #1;
        rst_n = 1'b1;
        model_reset();

        // Free run: 600 cycles is one minute at this prescale.
        repeat (600) cycle();
        check("run600_sec", bus.sec, 0);
        check("run600_min", bus.min, 1);
        check("run600_hour", bus.hour, 0);

        repeat ($urandom_range(0, 9)) cycle();
        press(1'b1, 1'b0);
        check("enter_set_hour", bus.mode, 1);
        repeat (20) cycle();
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        check("hour_after_3_inc", bus.hour, 3);

        // Short glitch on inc must be ignored.
        bus.btn_inc = 1'b1;
        cycle(); cycle();
        bus.btn_inc = 1'b0;
        repeat (12) cycle();
        check("glitch_hour", bus.hour, 3);

        while (m_h != 23) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        while (m_m != 59) press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("min_wrap", bus.min, 0);
        check("min_wrap_hour", bus.hour, 23);
        while (m_m != 59) press(1'b0, 1'b1);

        // Mode and inc accepted together: mode advances, min stays.
        press(1'b1, 1'b1);
        check("simul_mode", bus.mode, 3);
        check("simul_min", bus.min, 59);

        while (m_s != 59) press(1'b0, 1'b1);
        repeat (100) cycle();
        check("frozen_sec", bus.sec, 59);
        check("frozen_min", bus.min, 59);

        // Back to RUN at 23:59:59; rollover lands 10 cycles after RUN shows.
        press(1'b1, 1'b0);
        check("rollover_sec", bus.sec, 0);
        check("rollover_min", bus.min, 0);
        check("rollover_hour", bus.hour, 0);

        repeat ($urandom_range(20, 200)) cycle();

        press(1'b1, 1'b0);
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        while (m_m != 17) press(1'b0, 1'b1);
        repeat ($urandom_range(1, 7)) cycle();
        check("pre_reset_mode", bus.mode, 2);
        check("pre_reset_min", bus.min, 17);

        // Asynchronous reset mid-edit, between clock edges.
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk_1000hz); #1;
        check_all_zero("reset_held");
        rst_n = 1'b1;
        model_reset();
        repeat (150) cycle();
        check("resume_sec", bus.sec, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
